apb4_master_bridge: RTL
=======================

// Module: apb4_master_bridge
// PURPOSE
// - APB4 requester: turns a valid/ready request from a bus host/CPU into one APB4 SETUP/ACCESS transfer.
// - Returns read data, slave error or timeout on a valid/ready response channel.
// - Drives the slave side of peripherals such as the RCU and timers.
// - Single outstanding transfer; single clock domain (pclk).
// PARAMETERS
// - ADDR_WIDTH      32   paddr / req_addr width
// - DATA_WIDTH      32   pwdata/prdata width; must be 8, 16 or 32
// - TIMEOUT_CYCLES  256  ACCESS cycles without pready before abort; 0 disables timeout
// PORTS
// - pclk           in   1             bus clock; all logic on rising edge
// - prst           in   1             asynchronous, active-high reset
// - req_valid_i    in   1             request present
// - req_ready_o    out  1             request accepted when valid&&ready
// - req_addr_i     in   ADDR_WIDTH    byte address
// - req_write_i    in   1             1 = write, 0 = read
// - req_wdata_i    in   DATA_WIDTH    write data
// - req_strb_i     in   DATA_WIDTH/8  write byte strobes
// - req_prot_i     in   3             APB4 pprot
// - rsp_valid_o    out  1             response present
// - rsp_ready_i    in   1             response consumed when valid&&ready
// - rsp_rdata_o    out  DATA_WIDTH    read data; 0 for writes and on error/timeout
// - rsp_err_o      out  1             pslverr or timeout
// - rsp_timeout_o  out  1             transfer aborted by timeout
// - paddr_o, pprot_o, pwrite_o, pwdata_o, pstrb_o   out   APB4 request fields
// - psel_o, penable_o                               out   1
// - pready_i, pslverr_i                             in    1
// - prdata_i                                        in    DATA_WIDTH
// BEHAVIOUR
// - Reset (prst=1, async): state IDLE; all outputs 0 except req_ready_o=1; timeout count 0.
// - Reset mid-transfer: psel_o/penable_o drop immediately; any pending response is lost.
// - FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
// - req_ready_o = (state==IDLE). Combinational from state; never depends on req_valid_i.
// - IDLE: on valid&&ready, register addr/write/wdata/strb/prot; next state SETUP.
// - SETUP (one cycle): psel_o=1, penable_o=0; next state ACCESS.
// - ACCESS: psel_o=1, penable_o=1; held until pready_i=1 or timeout.
// - pready_i=1 in ACCESS:
//   - capture prdata_i (reads only) and pslverr_i;
//   - psel/penable=0 next cycle; next state RESP.
// - RESP: rsp_valid_o=1; rsp_* fields stable until rsp_ready_i=1, then IDLE.
// - APB fields:
//   - paddr/pwrite/pwdata/pprot come from registers; stable SETUP through ACCESS; hold last value in IDLE.
//   - pstrb_o forced to 0 for reads; pwdata_o is don't-care for reads (driven 0).
// - Timeout counter:
//   - cleared on SETUP entry; +1 each ACCESS cycle with pready_i=0.
//   - count reaching TIMEOUT_CYCLES aborts the transfer: psel/penable drop; RESP with rsp_err_o=1, rsp_timeout_o=1, rdata=0.
//   - pready_i=1 in the same cycle as expiry: pready wins; normal completion, no timeout.
// - Latency:
//   - accept at cycle N: SETUP N+1, ACCESS N+2.
//   - pready at N+2 gives rsp_valid at N+3.
//   - min 4 cycles per transfer; no back-to-back overlap.
// - rsp_err_o = pslverr_i | timeout; pslverr on a read also forces rdata=0.
// STRUCTURE
// - Package apb4_master_pkg:
//   - typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb4_mst_state_e;
//   - localparam TO_WIDTH = $clog2(TIMEOUT_CYCLES+1).
// - Sub-module apb4_mst_tmo_cnt: clear/enable/expire counter; tied off when TIMEOUT_CYCLES=0.
// - Request/response registers: existing dffr-style flops with async active-high reset variant.
// TESTING
// - Write 0x0000_0004 <- 0xA5A5_1234, strb 0xF, slave pready=1:
//   - psel N+1, penable N+2, rsp_valid N+3, err=0, rdata=0.
// - Read 0x0000_0008, slave waits 3 cycles then prdata=0xDEAD_BEEF, pready=1:
//   - paddr stable throughout; rsp_rdata=0xDEAD_BEEF, err=0.
// - Read with pslverr=1 at pready: rsp_err=1, rsp_timeout=0, rdata=0.
// - TIMEOUT_CYCLES=4, pready held 0:
//   - after 4 ACCESS cycles psel drops; rsp_err=1, rsp_timeout=1.
//   - Repeat with pready=1 on cycle 4: normal completion.
// - rsp_ready=0 for 5 cycles: rsp fields stable, req_ready=0; then IDLE, next request accepted.
// - Assert prst during ACCESS: psel/penable/rsp_valid=0 immediately, req_ready=1 after release.

Source files
------------

// File: rtl/apb4_master_pkg.sv
// Shared types and sizing helpers for the APB4 requester bridge.
package apb4_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb4_mst_state_e;

  localparam int TIMEOUT_CYCLES_DFLT = 256;
  localparam int TO_WIDTH = $clog2(TIMEOUT_CYCLES_DFLT + 1);

  // Counter width for a given timeout; at least one bit so a disabled timeout still elaborates.
  function automatic int to_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb4_mst_tmo_cnt.sv
// ACCESS-phase wait counter: cleared when a transfer is accepted, counts unanswered
// ACCESS cycles and flags expiry on the cycle the count would reach TIMEOUT_CYCLES.
module apb4_mst_tmo_cnt
  import apb4_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT,
  parameter int CNT_W          = to_width(TIMEOUT_CYCLES)
) (
  input  logic pclk,
  input  logic prst,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      logic unused_s;
      assign unused_s = ^{pclk, prst, clear_i, en_i};
      assign expire_o = 1'b0;
    end else begin : g_enabled
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Next count: clear wins over increment.
      always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
          cnt_d = {CNT_W{1'b0}};
        end else if (en_i) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end

      // Count register.
      always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
          cnt_q <= {CNT_W{1'b0}};
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/apb4_master_bridge.sv
// APB4 requester: one valid/ready request becomes one SETUP/ACCESS transfer,
// answered on a valid/ready response channel with data, slave error or timeout.
module apb4_master_bridge
  import apb4_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic                    req_write_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  output logic                    psel_o,
  output logic                    penable_o,
  input  logic                    pready_i,
  input  logic                    pslverr_i,
  input  logic [DATA_WIDTH-1:0]   prdata_i
);

  localparam int STRB_W = DATA_WIDTH / 8;

  apb4_mst_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic [2:0]            prot_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  tmo_q;

  logic accept_s;
  logic done_s;
  logic wait_s;
  logic expire_s;

  assign accept_s = req_valid_i && (state_q == IDLE);
  assign done_s   = (state_q == ACCESS) && pready_i;
  assign wait_s   = (state_q == ACCESS) && !pready_i;

  // Expiry is only raised while pready_i is low, so a same-cycle pready completes normally.
  apb4_mst_tmo_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo_cnt (
    .pclk     (pclk),
    .prst     (prst),
    .clear_i  (accept_s),
    .en_i     (wait_s),
    .expire_o (expire_s)
  );

  // State register.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = SETUP;
        else          state_d = IDLE;
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (done_s || expire_s) state_d = RESP;
        else                    state_d = ACCESS;
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
        else             state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and bus-phase outputs decoded from the registered state.
  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    case (state_q)
      IDLE:   req_ready_o = 1'b1;
      SETUP:  psel_o      = 1'b1;
      ACCESS: begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      RESP:   rsp_valid_o = 1'b1;
      default: begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
      end
    endcase
  end

  // Request fields, captured on acceptance and held until the next one.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      addr_q  <= {ADDR_WIDTH{1'b0}};
      write_q <= 1'b0;
      wdata_q <= {DATA_WIDTH{1'b0}};
      strb_q  <= {STRB_W{1'b0}};
      prot_q  <= 3'b000;
    end else if (accept_s) begin
      addr_q  <= req_addr_i;
      write_q <= req_write_i;
      wdata_q <= req_wdata_i;
      strb_q  <= req_strb_i;
      prot_q  <= req_prot_i;
    end else begin
      addr_q  <= addr_q;
      write_q <= write_q;
      wdata_q <= wdata_q;
      strb_q  <= strb_q;
      prot_q  <= prot_q;
    end
  end

  // Response fields; read data is zeroed for writes, slave errors and timeouts.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      rdata_q <= {DATA_WIDTH{1'b0}};
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else if (done_s) begin
      rdata_q <= (!write_q && !pslverr_i) ? prdata_i : {DATA_WIDTH{1'b0}};
      err_q   <= pslverr_i;
      tmo_q   <= 1'b0;
    end else if (expire_s) begin
      rdata_q <= {DATA_WIDTH{1'b0}};
      err_q   <= 1'b1;
      tmo_q   <= 1'b1;
    end else begin
      rdata_q <= rdata_q;
      err_q   <= err_q;
      tmo_q   <= tmo_q;
    end
  end

  assign paddr_o       = addr_q;
  assign pprot_o       = prot_q;
  assign pwrite_o      = write_q;
  assign pwdata_o      = write_q ? wdata_q : {DATA_WIDTH{1'b0}};
  assign pstrb_o       = write_q ? strb_q  : {STRB_W{1'b0}};
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = tmo_q;

endmodule
